// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per clock, borrow carried in a flop.
// Valid/ready on both sides; result is {borrow_out, difference}.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands, o_ready=1
// BUSY  | shifting operands LSB first, one bit per clock, o_busy=1
// DONE  | result held on o_result, o_valid=1 until i_ready
module serial_ripple_borrow_subtractor #(
    parameter int WIDTH = 10,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_sub_term1,
    input  logic [WIDTH-1:0] i_sub_term2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             br_next;

    assign d_bit   = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            o_result <= '0;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        a_sr    <= i_sub_term1;
                        b_sr    <= i_sub_term2;
                        br      <= 1'b0;
                        cnt     <= '0;
                        state   <= BUSY;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    d_sr <= {d_bit, d_sr[WIDTH-1:1]};
                    br   <= br_next;
                    cnt  <= cnt + CNT_W'(1);
                    // Last bit: d_sr still holds the lower WIDTH-1 bits one place too high.
                    if (cnt == LAST_BIT) begin
                        o_result <= {br_next, d_bit, d_sr[WIDTH-1:1]};
                        state    <= DONE;
                        o_busy   <= 1'b0;
                        o_valid  <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Bench for serial_ripple_borrow_subtractor: arithmetic/timeline model plus
// directed literal cases and randomized operations.
module tb_serial_ripple_borrow_subtractor;
    localparam int W = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic [W-1:0]  t1 = '0;
    logic [W-1:0]  t2 = '0;
    logic          o_ready;
    logic          o_valid;
    logic          o_busy;
    logic [W:0]    o_result;

    int checks = 0;
    int errors = 0;

    serial_ripple_borrow_subtractor #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_sub_term1(t1), .i_sub_term2(t2), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Timeline model: 0 = waiting, 1 = computing (m_left clocks remain), 2 = holding result.
    int         m_st = 0;
    int         m_left = 0;
    logic [W:0] m_pend = '0;
    logic [W:0] m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0;
            m_left = 0;
            m_res = '0;
        end else begin
            case (m_st)
                0: if (i_valid) begin
                    m_pend = {1'b0, t1} - {1'b0, t2};
                    m_left = W;
                    m_st = 1;
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_res = m_pend;
                        m_st = 2;
                    end
                end
                default: if (i_ready) m_st = 0;
            endcase
        end
    end

    task automatic chk(input logic ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) chk(1'b0, "ready_timeout", 0, 1);
    endtask

    // One operation: accept, measure latency, check result, hold in DONE, release.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W:0] exp, input int hold);
        int n;
        logic [W:0] held;
        wait_ready();
        t1 = a; t2 = b; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk);
        #1 i_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (o_valid) break;
        end
        chk(n == W, "latency", n, W);
        chk(o_result == exp, "result", int'(o_result), int'(exp));
        held = o_result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk(o_valid == 1'b1, "hold_valid", int'(o_valid), 1);
            chk(o_result == held, "hold_result", int'(o_result), int'(held));
        end
        @(negedge clk) i_ready = 1'b1;
        @(posedge clk);
        #1 chk(o_ready == 1'b1, "ready_after_done", int'(o_ready), 1);
        i_ready = 1'b0;
    endtask

    logic [W-1:0] bb_a [3] = '{10'd7, 10'd3, 10'd100};
    logic [W-1:0] bb_b [3] = '{10'd3, 10'd7, 10'd100};
    logic [W:0]   bb_e [3] = '{11'h004, 11'h7FC, 11'h000};

    initial begin
        rst_n = 1'b0;
        // Per-cycle comparison of every output against the model.
        fork
            forever begin
                @(negedge clk);
                chk(o_ready == (m_st == 0), "cyc_ready", int'(o_ready), int'(m_st == 0));
                chk(o_busy  == (m_st == 1), "cyc_busy",  int'(o_busy),  int'(m_st == 1));
                chk(o_valid == (m_st == 2), "cyc_valid", int'(o_valid), int'(m_st == 2));
                chk(o_result == m_res, "cyc_result", int'(o_result), int'(m_res));
            end
        join_none

        #12;
        chk(o_ready == 1'b1 && o_busy == 1'b0 && o_valid == 1'b0, "reset_flags",
            int'({o_ready, o_busy, o_valid}), 3'b100);
        chk(o_result == '0, "reset_result", int'(o_result), 0);
        @(negedge clk) rst_n = 1'b1;

        run_op(10'd1000, 10'd1,    11'h3E7, 0);
        run_op(10'd5,    10'd7,    11'h7FE, 0);
        run_op(10'd0,    10'd1023, 11'h401, 1);
        run_op(10'd0,    10'd0,    11'h000, 0);
        run_op(10'd1023, 10'd1023, 11'h000, 0);
        run_op(10'd1023, 10'd0,    11'h3FF, 0);
        run_op(10'd512,  10'd513,  11'h7FF, 0);

        // Backpressure with operand noise and i_valid pulses while busy.
        wait_ready();
        t1 = 10'd300; t2 = 10'd45; i_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            t1 = W'($urandom_range(0, 1023)); t2 = W'($urandom_range(0, 1023));
            i_valid = i[0];
            chk(o_ready == 1'b0, "busy_not_ready", int'(o_ready), 0);
        end
        i_valid = 1'b0;
        begin : bp_wait
            int n = 0;
            while (!o_valid && n < 20) begin @(negedge clk); n++; end
        end
        chk(o_result == 11'h0FF, "bp_result", int'(o_result), 11'h0FF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(o_valid && o_result == 11'h0FF, "bp_hold", int'(o_result), 11'h0FF);
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1 chk(o_ready == 1'b1, "bp_release", int'(o_ready), 1);
        i_ready = 1'b0;

        // Asynchronous reset in the middle of a computation.
        wait_ready();
        t1 = 10'd600; t2 = 10'd100; i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk(o_valid == 1'b0 && o_busy == 1'b0 && o_ready == 1'b1, "abort_flags",
            int'({o_ready, o_busy, o_valid}), 3'b100);
        chk(o_result == '0, "abort_result", int'(o_result), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(10'd600, 10'd100, 11'h1F4, 0);

        // Back-to-back with i_valid held high.
        wait_ready();
        i_ready = 1'b1;
        begin : b2b
            int idx = 0, ridx = 0, cyc = 0, last = -1;
            while (ridx < 3 && cyc < 100) begin
                if (o_valid) begin
                    chk(o_result == bb_e[ridx], "b2b_result", int'(o_result), int'(bb_e[ridx]));
                    if (last >= 0) chk(cyc - last == W + 2, "b2b_interval", cyc - last, W + 2);
                    last = cyc;
                    ridx++;
                end
                if (o_ready) begin
                    if (idx < 3) begin
                        t1 = bb_a[idx]; t2 = bb_b[idx]; i_valid = 1'b1; idx++;
                    end else i_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            chk(ridx == 3, "b2b_count", ridx, 3);
        end
        i_valid = 1'b0;
        i_ready = 1'b0;

        // Randomized operations; expected value from plain unsigned arithmetic.
        for (int k = 0; k < 30; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 1023));
            rb = W'($urandom_range(0, 1023));
            if (k % 5 == 0) rb = ra;
            run_op(ra, rb, {1'b0, ra} - {1'b0, rb}, int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
